// File: rtl/modbus_tx_framer_if.sv
// Signal bundle between the Modbus RTU TX framer, its requester, payload RAM and UART.
// The master modport is the framer's view; slave is the surrounding environment.
interface modbus_tx_framer_if;
  logic       start;
  logic [7:0] slave_addr;
  logic [7:0] func_code;
  logic [7:0] payload_len;
  logic [7:0] pl_rd_addr;
  logic [7:0] pl_rd_data;
  logic       send_en;
  logic [7:0] data_byte;
  logic       tx_done;
  logic       busy;
  logic       frame_done;
  logic       err;

  modport master (
    input  start, slave_addr, func_code, payload_len, pl_rd_data, tx_done,
    output pl_rd_addr, send_en, data_byte, busy, frame_done, err
  );

  modport slave (
    output start, slave_addr, func_code, payload_len, pl_rd_data, tx_done,
    input  pl_rd_addr, send_en, data_byte, busy, frame_done, err
  );
endinterface

// File: rtl/modbus_tx_framer.sv
// Modbus RTU transmit framer: addr, func, payload, CRC-16 (lo, hi) byte-by-byte to a UART,
// followed by a 3.5-character silent interval before the frame is reported done.
module modbus_tx_framer #(
  parameter int unsigned T35_CYCLES = 182280,
  parameter int unsigned TX_TIMEOUT = 1048575
) (
  input  logic               clk,
  input  logic               rst_n,
  modbus_tx_framer_if.master bus
);
  localparam int T35_W = $clog2(T35_CYCLES + 1);
  localparam int TO_W  = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_DONE, GAP} state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_addr, r_func, r_len, r_data_byte, r_pl_rd_addr;
  logic [8:0]       r_idx;
  logic [15:0]      r_crc;
  logic [T35_W-1:0] r_gap;
  logic [TO_W-1:0]  r_to;

  logic [7:0] w_byte;
  logic [8:0] w_idx_inc, w_total;
  logic       w_send_en, w_frame_done, w_err;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    return x;
  endfunction

  assign w_idx_inc = r_idx + 9'd1;
  assign w_total   = {1'b0, r_len} + 9'd4;

  // Byte index 0/1 header, 2..N+1 payload (RAM data already valid in LOAD), then CRC lo/hi
  always_comb begin
    w_byte = r_crc[15:8];
    if (r_idx == 9'd0)                      w_byte = r_addr;
    else if (r_idx == 9'd1)                 w_byte = r_func;
    else if (r_idx < w_total - 9'd2)        w_byte = bus.pl_rd_data;
    else if (r_idx == w_total - 9'd2)       w_byte = r_crc[7:0];
  end

  always_comb begin
    w_next       = r_state;
    w_send_en    = 1'b0;
    w_frame_done = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      IDLE:  if (bus.start) w_next = LOAD;
      FETCH: w_next = LOAD;
      LOAD: begin
        w_send_en = 1'b1;
        w_next    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (w_idx_inc >= w_total)                                   w_next = GAP;
          else if (w_idx_inc >= 9'd2 && w_idx_inc < w_total - 9'd2)   w_next = FETCH;
          else                                                        w_next = LOAD;
        end else if (r_to == TO_W'(TX_TIMEOUT - 1)) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end
      end
      GAP: if (r_gap == T35_W'(T35_CYCLES)) begin
        w_frame_done = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= 8'h00;
      r_func       <= 8'h00;
      r_len        <= 8'h00;
      r_data_byte  <= 8'h00;
      r_pl_rd_addr <= 8'h00;
      r_idx        <= 9'd0;
      r_crc        <= 16'hFFFF;
      r_gap        <= '0;
      r_to         <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_addr       <= bus.slave_addr;
          r_func       <= bus.func_code;
          r_len        <= (bus.payload_len > 8'd252) ? 8'd252 : bus.payload_len;
          r_crc        <= 16'hFFFF;
          r_idx        <= 9'd0;
          r_pl_rd_addr <= 8'h00;
        end
        LOAD: begin
          r_data_byte <= w_byte;
          r_to        <= '0;
          if (r_idx < w_total - 9'd2) r_crc <= crc_byte(r_crc, w_byte);
        end
        WAIT_DONE: begin
          r_to <= r_to + TO_W'(1);
          if (bus.tx_done) begin
            r_idx <= w_idx_inc;
            r_gap <= '0;
            if (w_next == FETCH) r_pl_rd_addr <= 8'(w_idx_inc - 9'd2);
          end
        end
        GAP:     r_gap <= r_gap + T35_W'(1);
        default: ;
      endcase
    end
  end

  // Hold the byte live during LOAD so it is already valid alongside send_en
  assign bus.data_byte  = (r_state == LOAD) ? w_byte : r_data_byte;
  assign bus.send_en    = w_send_en;
  assign bus.frame_done = w_frame_done;
  assign bus.err        = w_err;
  assign bus.busy       = (r_state != IDLE);
  assign bus.pl_rd_addr = r_pl_rd_addr;
endmodule

// File: tb/tb_modbus_tx_framer.sv
// Self-checking bench: UART responder with random latency, payload RAM model and a
// frame-level reference (byte list + bit-serial CRC) compared against captured traffic.
module tb_modbus_tx_framer;
  localparam int T35 = 20;
  localparam int TMO = 150;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  modbus_tx_framer_if bus();

  modbus_tx_framer #(.T35_CYCLES(T35), .TX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];
  always @(posedge clk) bus.pl_rd_data <= mem[bus.pl_rd_addr];

  // responder / monitor state
  int dly_min = 1, dly_max = 4, withhold = -1;
  bit pending = 0;
  int tgt = 0, txd_last = 0, fd_cnt = 0, err_cnt = 0, fd_cyc = 0, err_cyc = 0;
  int viol = 0, max_addr = 0;
  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  int sen_q[$];
  int addr_q[$];

  initial forever begin
    @(negedge clk);
    if (bus.busy && int'(bus.pl_rd_addr) > max_addr) max_addr = int'(bus.pl_rd_addr);
    if (bus.frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (bus.err) begin err_cnt++; err_cyc = cyc; end
    if (!rst_n) begin
      pending     = 0;
      bus.tx_done = 1'b0;
    end else begin
      if (pending && cyc == tgt && byte_q.size() > 0 && bus.data_byte !== byte_q[$]) viol++;
      bus.tx_done = pending && (cyc == tgt);
      if (bus.tx_done) begin pending = 0; txd_last = cyc; end
      if (bus.send_en) begin
        if (pending || cyc <= txd_last) viol++;
        byte_q.push_back(bus.data_byte);
        sen_q.push_back(cyc);
        addr_q.push_back(int'(bus.pl_rd_addr));
        if (int'(byte_q.size()) - 1 != withhold) begin
          pending = 1;
          tgt = cyc + int'($urandom_range(dly_max, dly_min));
        end
      end
    end
  end

  task automatic clr();
    byte_q.delete(); sen_q.delete(); addr_q.delete();
    fd_cnt = 0; err_cnt = 0; max_addr = 0;
  endtask

  // Reference frame: header, clamped payload, then CRC computed one message bit at a time
  task automatic build_exp(input logic [7:0] a, input logic [7:0] f, input logic [7:0] l);
    int n;
    logic [15:0] c;
    bit fb;
    n = (l > 8'd252) ? 252 : int'(l);
    exp_q.delete();
    exp_q.push_back(a);
    exp_q.push_back(f);
    for (int k = 0; k < n; k++) exp_q.push_back(mem[k]);
    c = 16'hFFFF;
    foreach (exp_q[i]) for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ exp_q[i][b];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  function automatic int first_diff();
    if (byte_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (byte_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic start_frame(input logic [7:0] a, input logic [7:0] f, input logic [7:0] l);
    @(posedge clk); #1;
    bus.slave_addr = a; bus.func_code = f; bus.payload_len = l; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (!bus.busy) begin ok = 1; break; end
    end
  endtask

  task automatic wait_sends(input int n, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (int'(sen_q.size()) >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.send_en !== 1'b0) begin failures++; $display("FAIL reset_send_en got=%b want=0", bus.send_en); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.err); end
    checks++; if (bus.data_byte !== 8'h00) begin failures++; $display("FAIL reset_data_byte got=%h want=00", bus.data_byte); end
    checks++; if (bus.pl_rd_addr !== 8'h00) begin failures++; $display("FAIL reset_pl_rd_addr got=%h want=00", bus.pl_rd_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_read_holding();
    logic [7:0] lit [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
    bit ok;
    int bad;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h0A;
    dly_min = 100; dly_max = 100;
    clr();
    start_frame(8'h01, 8'h03, 8'd4);
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rh_timeout busy still high"); end
    build_exp(8'h01, 8'h03, 8'd4);
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL rh_model diff_at=%0d size=%0d want_size=%0d", first_diff(), byte_q.size(), exp_q.size()); end
    bad = (byte_q.size() != 8) ? 1 : 0;
    if (bad == 0) foreach (lit[i]) if (byte_q[i] !== lit[i]) bad = 1;
    checks++; if (bad != 0) begin failures++; $display("FAIL rh_literal got_size=%0d want 01 03 00 00 00 0A C5 CD", byte_q.size()); end
    checks++; if (fd_cyc - txd_last != T35 + 1) begin failures++; $display("FAIL rh_gap got=%0d want=%0d", fd_cyc - txd_last, T35 + 1); end
    checks++; if (fd_cnt != 1 || err_cnt != 0) begin failures++; $display("FAIL rh_done got fd=%0d err=%0d want fd=1 err=0", fd_cnt, err_cnt); end
  endtask

  task automatic test_len0();
    logic [7:0] lit [4] = '{8'h01, 8'h07, 8'h41, 8'hE2};
    bit ok;
    int bad;
    dly_min = 1; dly_max = 5;
    clr();
    start_frame(8'h01, 8'h07, 8'd0);
    wait_idle(500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL len0_timeout busy still high"); end
    checks++; if (sen_q.size() != 4) begin failures++; $display("FAIL len0_count got=%0d want=4", sen_q.size()); end
    bad = (byte_q.size() != 4) ? 1 : 0;
    if (bad == 0) foreach (lit[i]) if (byte_q[i] !== lit[i]) bad = 1;
    checks++; if (bad != 0) begin failures++; $display("FAIL len0_bytes mismatch want 01 07 41 E2"); end
    checks++; if (max_addr != 0) begin failures++; $display("FAIL len0_addr got=%0d want=0", max_addr); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL len0_done got=%0d want=1", fd_cnt); end
  endtask

  task automatic test_random();
    bit ok;
    int bad;
    logic [7:0] a, f, l;
    for (int t = 0; t < 6; t++) begin
      a = 8'($urandom); f = 8'($urandom); l = 8'($urandom_range(20, 0));
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      dly_min = 1; dly_max = 8;
      clr();
      start_frame(a, f, l);
      wait_idle(1500, ok);
      build_exp(a, f, l);
      checks++; if (!ok || first_diff() != -1) begin failures++; $display("FAIL rand%0d_frame done=%0b diff_at=%0d len=%0d", t, ok, first_diff(), l); end
      bad = 0;
      for (int k = 0; k < int'(l); k++) if (addr_q.size() > k + 2 && addr_q[k + 2] != k) bad++;
      checks++; if (bad != 0 || fd_cnt != 1 || err_cnt != 0) begin failures++; $display("FAIL rand%0d_ctl addr_bad=%0d fd=%0d err=%0d want 0/1/0", t, bad, fd_cnt, err_cnt); end
    end
    checks++; if (viol != 0) begin failures++; $display("FAIL handshake_violations got=%0d want=0", viol); end
  endtask

  task automatic test_busy_start();
    bit ok;
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    dly_min = 10; dly_max = 20;
    clr();
    start_frame(8'h11, 8'h10, 8'd6);
    wait_sends(2, 200, ok);
    bus.slave_addr = 8'h44; bus.func_code = 8'h22; bus.payload_len = 8'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(1000, ok);
    repeat (50) @(posedge clk);
    #1;
    build_exp(8'h11, 8'h10, 8'd6);
    checks++; if (!ok || first_diff() != -1) begin failures++; $display("FAIL busy_start_frame done=%0b diff_at=%0d", ok, first_diff()); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL busy_start_done got=%0d want=1", fd_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    dly_min = 2; dly_max = 6; withhold = 2;
    clr();
    start_frame(8'h05, 8'h06, 8'd5);
    wait_idle(500, ok);
    withhold = -1;
    checks++; if (!ok || err_cnt != 1) begin failures++; $display("FAIL to_err done=%0b err=%0d want 1", ok, err_cnt); end
    checks++; if (sen_q.size() != 3 || err_cyc - sen_q[2] != TMO) begin failures++; $display("FAIL to_latency sends=%0d got=%0d want=%0d", sen_q.size(), (sen_q.size() == 3) ? err_cyc - sen_q[2] : -1, TMO); end
    repeat (T35 + 10) @(posedge clk);
    #1;
    checks++; if (fd_cnt != 0 || bus.busy !== 1'b0) begin failures++; $display("FAIL to_no_done fd=%0d busy=%b want 0/0", fd_cnt, bus.busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    dly_min = 3; dly_max = 6;
    clr();
    start_frame(8'h21, 8'h10, 8'd10);
    wait_sends(5, 300, ok);
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.send_en, bus.frame_done, bus.err} !== 4'b0 || bus.data_byte !== 8'h00 || bus.pl_rd_addr !== 8'h00) begin
      failures++; $display("FAIL midrst_outputs busy=%b send_en=%b data=%h addr=%h want all 0", bus.busy, bus.send_en, bus.data_byte, bus.pl_rd_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = sen_q.size();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (int'(sen_q.size()) != n) begin failures++; $display("FAIL midrst_quiet got=%0d want=%0d", sen_q.size(), n); end
    clr();
    start_frame(8'h22, 8'h04, 8'd8);
    wait_idle(500, ok);
    build_exp(8'h22, 8'h04, 8'd8);
    checks++; if (!ok || first_diff() != -1 || fd_cnt != 1) begin failures++; $display("FAIL midrst_fresh done=%0b diff_at=%0d fd=%0d", ok, first_diff(), fd_cnt); end
  endtask

  task automatic test_clamp();
    bit ok;
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    dly_min = 1; dly_max = 3;
    clr();
    start_frame(8'h7F, 8'h10, 8'hFF);
    wait_idle(4000, ok);
    build_exp(8'h7F, 8'h10, 8'hFF);
    checks++; if (!ok || byte_q.size() != 256) begin failures++; $display("FAIL clamp_count done=%0b got=%0d want=256", ok, byte_q.size()); end
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL clamp_bytes diff_at=%0d", first_diff()); end
    checks++; if (max_addr != 251) begin failures++; $display("FAIL clamp_addr got=%0d want=251", max_addr); end
    checks++; if (viol != 0) begin failures++; $display("FAIL final_handshake_violations got=%0d want=0", viol); end
  endtask

  initial begin
    bus.start = 1'b0; bus.slave_addr = 8'h00; bus.func_code = 8'h00; bus.payload_len = 8'h00;
    bus.tx_done = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    test_reset();
    test_read_holding();
    test_len0();
    test_random();
    test_busy_start();
    test_timeout();
    test_reset_mid();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
